mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-ported memory between two requesters: instruction fetch (IMEM) and load/store (DMEM).
//  Arbitrates put requests round-robin and logs the winner of each put in an in-order tag FIFO.
//  Routes each get response back to the requester that issued the matching put.
//  Sits between the RV core's two memory interfaces and the memory block; all ports use the mem_op put/get handshake.
// PARAMETERS
//  DEPTH       2   max in-flight puts tracked by the tag FIFO (power of 2, >=1)
//  DEPTH_LOG2  1   log2(DEPTH); width of FIFO pointers
// PORTS
//  CLK                  in   1   clock; all state updates on posedge
//  RST_N                in   1   reset, synchronous, active-low
//  imem_put_enable      in   1   IMEM presents a request
//  imem_put_request     in   mem_op  IMEM request {byte_en, addr, data}
//  imem_put_ready       out  1   IMEM request accepted this cycle if enable=1
//  imem_get_enable      in   1   IMEM takes its response
//  imem_get_ready       out  1   response at FIFO head belongs to IMEM and is valid
//  imem_get_response    out  mem_op  passthrough of mem_get_response
//  dmem_*               same six ports as imem_*, for DMEM
//  mem_put_enable       out  1   forwarded put to memory
//  mem_put_request      out  mem_op  granted request (unmodified)
//  mem_put_ready        in   1   memory can accept a put
//  mem_get_enable       out  1   forwarded get to memory
//  mem_get_ready        in   1   memory has a response
//  mem_get_response     in   mem_op  memory response
// BEHAVIOUR
//  - Handshake: a transfer fires on a port when enable && ready in the same cycle. Enables do not depend on readies.
//  - Reset (RST_N==0 at posedge): FIFO count, rd_ptr and wr_ptr go to 0; last_grant goes to DMEM, so IMEM wins the first tie.
//    - While RST_N==0, all *_ready outputs and mem_put_enable/mem_get_enable are driven 0 combinationally.
//    - Reset mid-operation discards all tags; memory clears its own request on the same reset.
//  - Grant (combinational):
//    - can_push = RST_N && mem_put_ready && (count<DEPTH || pop).
//    - Only one requester valid: that requester is granted.
//    - Both valid: the requester != last_grant is granted.
//    - <p>_put_ready = can_push && grant==p. The loser sees ready=0 and must hold its request.
//  - Put path: mem_put_enable = any put_enable && can_push. mem_put_request = winner's request; IMEM's when idle (don't-care).
//  - Push: on a fired put, write the winner id at wr_ptr, increment wr_ptr mod DEPTH, and update last_grant to the winner.
//  - Get path:
//    - head = fifo[rd_ptr]; nonempty = count!=0.
//    - <p>_get_ready = RST_N && nonempty && mem_get_ready && head==p.
//    - mem_get_enable = get_enable of the head's owner, gated by nonempty.
//    - The non-owner's get_enable is ignored.
//  - Pop: when mem_get_enable && mem_get_ready, increment rd_ptr mod DEPTH.
//  - Push and pop may occur in the same cycle, including when full (pop frees the slot). Count is unchanged in that case.
//  - Responses are strictly in put order. Latency adds 0 cycles: all paths are combinational and only the tag FIFO is registered.
//  - A get is never forwarded when empty, even if mem_get_ready=1 (protocol error; assertion).
//  - No put is forwarded when full and no pop occurs; both put_ready outputs are 0.
//  - Responses pass through unmodified; both *_get_response outputs carry mem_get_response.
// STRUCTURE
//  - Shared package (typedefs.sv):
//    - mem_op (already present).
//    - New enum req_id_t {REQ_IMEM=1'b0, REQ_DMEM=1'b1}, used for grant, last_grant and FIFO entries.
//  - One sub-module, tag_fifo #(DEPTH, DEPTH_LOG2):
//    - 1-bit-wide synchronous FIFO with push/pop/full/empty/head.
//    - Supports same-cycle push+pop when full.
//  - Top level holds the grant logic, last_grant register and routing muxes.
// TESTING
//  1 Reset: hold RST_N=0 for 3 cycles with all enables=1 -> every ready=0, mem_*_enable=0. After release the first tie grants IMEM.
//  2 Solo IMEM: put addr=0x100, memory returns data=0xCAFEBABE -> imem_get_ready=1, response data=0xCAFEBABE, dmem_get_ready stays 0.
//  3 Tie: both enable every cycle with mem always ready -> grants alternate I,D,I,D over 8 puts; responses return in the same order.
//  4 Full FIFO: DEPTH=2, two puts accepted, hold mem_get_ready=0 -> both put_ready=0.
//     Then mem_get_ready=1 with get_enable -> pop and push fire in the same cycle and count stays 2.
//  5 Wrong owner: head=DMEM, imem_get_enable=1, dmem_get_enable=0 -> mem_get_enable=0 and no pop.
//  6 Mid-op reset: pull RST_N low with 1 tag in flight for 1 cycle -> count=0 afterwards and no stale get_ready after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: the mem_op transfer
// record and the requester id stored in the in-order tag FIFO.
package mem_arbiter_pkg;

    typedef struct packed {
        logic [3:0]  byte_en;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_op;

    typedef enum logic {
        REQ_IMEM = 1'b0,
        REQ_DMEM = 1'b1
    } req_id_t;

    // Round-robin pick: a lone requester wins; on a tie the one not granted last time wins.
    function automatic req_id_t rr_pick(input logic imem_v, input logic dmem_v, input req_id_t last);
        req_id_t pick;
        if (imem_v && dmem_v) begin
            pick = (last == REQ_DMEM) ? REQ_IMEM : REQ_DMEM;
        end else if (dmem_v) begin
            pick = REQ_DMEM;
        end else begin
            pick = REQ_IMEM;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter_tag_fifo.sv
// One-bit-wide in-order tag FIFO recording which requester owns each in-flight put.
// A push and a pop in the same cycle are legal even when full.
module mem_arbiter_tag_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int DEPTH_LOG2 = 1
) (
    input  logic    clk_i,
    input  logic    rst_n_i,
    input  logic    push_i,
    input  req_id_t push_id_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output req_id_t head_o
);

    localparam int PW = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [PW-1:0]       PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0]       PTR_ONE  = PW'(1);

    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] count_q,  count_d;
    req_id_t             slot_q [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign head_o  = slot_q[rd_ptr_q];

    // Next-state for pointers and occupancy.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage; stale slots are harmless because count gates every read.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            slot_q[wr_ptr_q] <= push_id_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between IMEM and DMEM: round-robin put
// arbitration, in-order tag tracking, and combinational response routing.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int DEPTH_LOG2 = 1
) (
    input  logic  CLK,
    input  logic  RST_N,
    input  logic  imem_put_enable,
    input  mem_op imem_put_request,
    output logic  imem_put_ready,
    input  logic  imem_get_enable,
    output logic  imem_get_ready,
    output mem_op imem_get_response,
    input  logic  dmem_put_enable,
    input  mem_op dmem_put_request,
    output logic  dmem_put_ready,
    input  logic  dmem_get_enable,
    output logic  dmem_get_ready,
    output mem_op dmem_get_response,
    output logic  mem_put_enable,
    output mem_op mem_put_request,
    input  logic  mem_put_ready,
    output logic  mem_get_enable,
    input  logic  mem_get_ready,
    input  mem_op mem_get_response
);

    req_id_t last_grant_q, last_grant_d;
    req_id_t grant_s;
    req_id_t head_s;
    logic    full_s, empty_s;
    logic    can_push_s, push_s, pop_s, get_en_s;

    assign grant_s    = rr_pick(imem_put_enable, dmem_put_enable, last_grant_q);
    assign pop_s      = get_en_s && mem_get_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign can_push_s = RST_N && mem_put_ready && (!full_s || pop_s);
    assign push_s     = (imem_put_enable || dmem_put_enable) && can_push_s;

    assign imem_put_ready  = can_push_s && (grant_s == REQ_IMEM);
    assign dmem_put_ready  = can_push_s && (grant_s == REQ_DMEM);
    assign mem_put_enable  = push_s;
    assign mem_put_request = (grant_s == REQ_DMEM) ? dmem_put_request : imem_put_request;

    assign get_en_s = RST_N && !empty_s &&
                      ((head_s == REQ_IMEM) ? imem_get_enable : dmem_get_enable);
    assign mem_get_enable = get_en_s;
    assign imem_get_ready = RST_N && !empty_s && mem_get_ready && (head_s == REQ_IMEM);
    assign dmem_get_ready = RST_N && !empty_s && mem_get_ready && (head_s == REQ_DMEM);

    assign imem_get_response = mem_get_response;
    assign dmem_get_response = mem_get_response;

    // Remember the winner of each accepted put for tie-breaking.
    always_comb begin
        last_grant_d = last_grant_q;
        if (push_s) begin
            last_grant_d = grant_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Reset leaves DMEM as last winner so IMEM takes the first tie.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            last_grant_q <= REQ_DMEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    mem_arbiter_tag_fifo #(
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tag_fifo (
        .clk_i     (CLK),
        .rst_n_i   (RST_N),
        .push_i    (push_s),
        .push_id_i (grant_s),
        .pop_i     (pop_s),
        .full_o    (full_s),
        .empty_o   (empty_s),
        .head_o    (head_s)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with DEPTH=2.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic  CLK = 1'b0;
    logic  RST_N;
    logic  imem_put_enable, imem_put_ready, imem_get_enable, imem_get_ready;
    logic  dmem_put_enable, dmem_put_ready, dmem_get_enable, dmem_get_ready;
    logic  mem_put_enable, mem_put_ready, mem_get_enable, mem_get_ready;
    mem_op imem_put_request, dmem_put_request, mem_put_request;
    mem_op imem_get_response, dmem_get_response, mem_get_response;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.DEPTH(2), .DEPTH_LOG2(1)) dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .imem_put_enable   (imem_put_enable),
        .imem_put_request  (imem_put_request),
        .imem_put_ready    (imem_put_ready),
        .imem_get_enable   (imem_get_enable),
        .imem_get_ready    (imem_get_ready),
        .imem_get_response (imem_get_response),
        .dmem_put_enable   (dmem_put_enable),
        .dmem_put_request  (dmem_put_request),
        .dmem_put_ready    (dmem_put_ready),
        .dmem_get_enable   (dmem_get_enable),
        .dmem_get_ready    (dmem_get_ready),
        .dmem_get_response (dmem_get_response),
        .mem_put_enable    (mem_put_enable),
        .mem_put_request   (mem_put_request),
        .mem_put_ready     (mem_put_ready),
        .mem_get_enable    (mem_get_enable),
        .mem_get_ready     (mem_get_ready),
        .mem_get_response  (mem_get_response)
    );

    // in  = {rst_n, imem_pe, dmem_pe, imem_ge, dmem_ge, mem_put_ready, mem_get_ready}
    // exp = {imem_pr, dmem_pr, imem_gr, dmem_gr, mem_put_enable, mem_get_enable}
    // a   = {check put addr, expected grant is DMEM}
    typedef struct packed {
        logic [6:0] in;
        logic [5:0] exp;
        logic [1:0] a;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [6:0] in, input logic [5:0] exp, input logic [1:0] a);
        vec_t v;
        v.in = in; v.exp = exp; v.a = a;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0;
        imem_put_enable = 1'b0; dmem_put_enable = 1'b0;
        imem_get_enable = 1'b0; dmem_get_enable = 1'b0;
        mem_put_ready = 1'b0;   mem_get_ready = 1'b0;
        imem_put_request = '{byte_en: 4'hF, addr: 32'h0000_0100, data: 32'h1111_1111};
        dmem_put_request = '{byte_en: 4'h3, addr: 32'h0000_0200, data: 32'h2222_2222};
        mem_get_response = '{byte_en: 4'hF, addr: 32'h0000_0000, data: 32'hCAFE_BABE};

        // Reset held 3 cycles with everything asserted
        for (int i = 0; i < 3; i++) add(7'b0111111, 6'b000000, 2'b00);
        // Tie with memory always ready: grants I,D,I,D... responses follow in order
        add(7'b1111111, 6'b100010, 2'b10);
        for (int i = 0; i < 3; i++) begin
            add(7'b1111111, 6'b011011, 2'b11);
            add(7'b1111111, 6'b100111, 2'b10);
        end
        add(7'b1111111, 6'b011011, 2'b11);
        add(7'b1001111, 6'b100101, 2'b10);
        // Fill to full, then pop+push in one cycle keeps it full
        add(7'b1100010, 6'b100010, 2'b10);
        add(7'b1010010, 6'b010010, 2'b11);
        add(7'b1110010, 6'b000000, 2'b10);
        add(7'b1111011, 6'b101011, 2'b10);
        add(7'b1110010, 6'b000000, 2'b11);
        // Head is DMEM: IMEM's get_enable must not pop
        add(7'b1001011, 6'b000100, 2'b10);
        add(7'b1000111, 6'b100101, 2'b10);
        add(7'b1000011, 6'b101000, 2'b10);
        // Reset with one tag in flight, then no stale response
        add(7'b0111111, 6'b000000, 2'b00);
        add(7'b1001111, 6'b100000, 2'b10);
        add(7'b1110011, 6'b100010, 2'b10);

        step();
        for (int i = 0; i < vecs.size(); i++) begin
            {RST_N, imem_put_enable, dmem_put_enable, imem_get_enable,
             dmem_get_enable, mem_put_ready, mem_get_ready} = vecs[i].in;
            #3;
            chk($sformatf("v%0d imem_put_ready", i), 32'(imem_put_ready), 32'(vecs[i].exp[5]));
            chk($sformatf("v%0d dmem_put_ready", i), 32'(dmem_put_ready), 32'(vecs[i].exp[4]));
            chk($sformatf("v%0d imem_get_ready", i), 32'(imem_get_ready), 32'(vecs[i].exp[3]));
            chk($sformatf("v%0d dmem_get_ready", i), 32'(dmem_get_ready), 32'(vecs[i].exp[2]));
            chk($sformatf("v%0d mem_put_enable", i), 32'(mem_put_enable), 32'(vecs[i].exp[1]));
            chk($sformatf("v%0d mem_get_enable", i), 32'(mem_get_enable), 32'(vecs[i].exp[0]));
            if (vecs[i].a[1]) begin
                chk($sformatf("v%0d put_addr", i), mem_put_request.addr,
                    vecs[i].a[0] ? 32'h0000_0200 : 32'h0000_0100);
            end
            step();
        end

        // Solo IMEM put and response routing
        RST_N = 1'b0;
        {imem_put_enable, dmem_put_enable, imem_get_enable, dmem_get_enable} = 4'b0000;
        step();
        RST_N = 1'b1; imem_put_enable = 1'b1; mem_put_ready = 1'b1; mem_get_ready = 1'b0;
        #3;
        chk("solo imem_put_ready", 32'(imem_put_ready), 32'h1);
        chk("solo dmem_put_ready", 32'(dmem_put_ready), 32'h0);
        chk("solo put addr", mem_put_request.addr, 32'h0000_0100);
        chk("solo put data", mem_put_request.data, 32'h1111_1111);
        step();
        imem_put_enable = 1'b0; imem_get_enable = 1'b1; mem_get_ready = 1'b1;
        #3;
        chk("solo imem_get_ready", 32'(imem_get_ready), 32'h1);
        chk("solo dmem_get_ready", 32'(dmem_get_ready), 32'h0);
        chk("solo mem_get_enable", 32'(mem_get_enable), 32'h1);
        chk("solo imem resp data", imem_get_response.data, 32'hCAFE_BABE);
        chk("solo dmem resp data", dmem_get_response.data, 32'hCAFE_BABE);
        step();
        #3;
        chk("empty imem_get_ready", 32'(imem_get_ready), 32'h0);
        chk("empty mem_get_enable", 32'(mem_get_enable), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
